// File: rtl/mod_corrector.sv
// -----------------------------------------------------------------------------
// mod_corrector
// Final correction stage of a modular adder-subtractor. It takes the raw signed
// sum/difference and the upstream comparison code {ge_q, nonneg}, then adds q,
// subtracts q or passes the value through. Results wait in a 2-entry output
// queue behind valid/ready handshakes.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers a value
//   in_ready   block can accept (registered state only)
//   var_1      signed raw sum/difference (5 bits)
//   q          signed modulus (5 bits, legal 1..15)
//   cmp        bit0 = var_1 >= 0, bit1 = var_1 >= q
//   out_valid  queue head holds a result
//   out_ready  downstream takes the head
//   out_data   signed corrected value at the queue head
//   out_err    head entry came from an illegal code
//   err_cnt    saturating count of accepted illegal codes
// -----------------------------------------------------------------------------
module mod_corrector #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [4:0]    var_1,
    input  logic signed [4:0]    q,
    input  logic [1:0]           cmp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [4:0]    out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Queue occupancy doubles as the FSM state (EMPTY/ONE/FULL = count 0/1/2).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [5:0]           r_mem [0:1];   // {data[4:0], err}
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [5:0]           r_head;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_push;
    logic                 w_pop;
    logic [5:0]           w_entry;
    logic                 w_rd_next;
    logic [5:0]           w_head_src;

    // Decode the comparison code; arithmetic at 6 bits, truncated to 5.
    function automatic logic [5:0] f_correct(
        input logic signed [4:0] v,
        input logic signed [4:0] m,
        input logic [1:0]        c
    );
        logic signed [5:0] v6;
        logic signed [5:0] m6;
        logic signed [5:0] res;
        logic              err;
        v6  = {v[4], v};
        m6  = {m[4], m};
        res = v6;
        err = 1'b0;
        case (c)
            2'b00:   begin res = v6 + m6; err = 1'b0; end
            2'b01:   begin res = v6;      err = 1'b0; end
            2'b11:   begin res = v6 - m6; err = 1'b0; end
            2'b10:   begin res = v6;      err = 1'b1; end
            default: begin res = v6;      err = 1'b1; end
        endcase
        return {res[4:0], err};
    endfunction

    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_entry   = f_correct(var_1, q, cmp);
    assign w_rd_next = r_rd_ptr ^ w_pop;

    // Next head: the freshly pushed entry when it lands in the slot the read
    // pointer moves to (empty push, or push+pop in ONE), otherwise storage.
    always_comb begin
        w_head_src = r_mem[w_rd_next];
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_src = w_entry;
        end else begin
            w_head_src = r_mem[w_rd_next];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic on push/pop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_next = ST_ONE;
                else        w_state_next = ST_EMPTY;
            end
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_next = ST_FULL;
                else if (!w_push && w_pop) w_state_next = ST_EMPTY;
                else                       w_state_next = ST_ONE;
            end
            ST_FULL: begin
                if (w_pop) w_state_next = ST_ONE;
                else       w_state_next = ST_FULL;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // FSM outputs: handshake flags decoded from the registered state only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            ST_EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
            ST_ONE:   begin in_ready = 1'b1; out_valid = 1'b1; end
            ST_FULL:  begin in_ready = 1'b0; out_valid = 1'b1; end
            default:  begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    // Queue storage, pointers, registered head and illegal-code counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0]  <= 6'd0;
            r_mem[1]  <= 6'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_head    <= 6'd0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // An empty queue keeps presenting the last head value.
            if (w_state_next != ST_EMPTY) begin
                r_head <= w_head_src;
            end
            if (w_push && w_entry[0] && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_data = r_head[5:1];
    assign out_err  = r_head[0];
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_mod_corrector.sv
module tb_mod_corrector;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [4:0] var_1;
    logic signed [4:0] q;
    logic [1:0]        cmp;
    logic              out_valid;
    logic              out_ready;
    logic signed [4:0] out_data;
    logic              out_err;
    logic [7:0]        err_cnt;

    int errors = 0;
    int checks = 0;

    mod_corrector #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .var_1     (var_1),
        .q         (q),
        .cmp       (cmp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of expected {data, err} results.
    typedef struct {
        int d;
        int e;
    } ent_t;

    ent_t mq[$];
    int   last_d;
    int   last_e;
    int   m_cnt;

    typedef struct {
        int         v;
        int         qq;
        logic [1:0] c;
        int         exp_d;
        int         exp_e;
    } vec_t;

    vec_t tv[$];

    function automatic int ref_data(input int v, input int qq, input logic [1:0] c);
        int r;
        case (c)
            2'b00:   r = v + qq;
            2'b11:   r = v - qq;
            default: r = v;
        endcase
        r = r & 31;
        if (r >= 16) r = r - 32;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare outputs against the model, step the model.
    task automatic cycle(input logic iv, input int v, input int qq,
                         input logic [1:0] c, input logic ordy, input logic r);
        bit   push;
        bit   pop;
        ent_t ne;
        in_valid  = iv;
        var_1     = v[4:0];
        q         = qq[4:0];
        cmp       = c;
        out_ready = ordy;
        rst       = r;
        #1;
        chk("in_ready",  int'(in_ready),  int'(mq.size() != 2));
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("out_data",  int'(out_data),  last_d);
        chk("out_err",   int'(out_err),   last_e);
        chk("err_cnt",   int'(err_cnt),   m_cnt);
        push = iv && (mq.size() != 2);
        pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (r) begin
            mq.delete();
            last_d = 0;
            last_e = 0;
            m_cnt  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                ne.d = ref_data(v, qq, c);
                ne.e = int'(c == 2'b10);
                mq.push_back(ne);
                if (ne.e == 1 && m_cnt < 255) m_cnt++;
            end
            if (mq.size() != 0) begin
                last_d = mq[0].d;
                last_e = mq[0].e;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 0, 7, 2'b01, ordy, 1'b0);
    endtask

    initial begin
        vec_t vr;
        int   v;
        int   qq;
        logic [1:0] c;

        // Table: legal codes with q=7 and the q=15 boundaries.
        vr = '{v: -3,  qq: 7,  c: 2'b00, exp_d: 4,  exp_e: 0}; tv.push_back(vr);
        vr = '{v: 5,   qq: 7,  c: 2'b01, exp_d: 5,  exp_e: 0}; tv.push_back(vr);
        vr = '{v: 9,   qq: 7,  c: 2'b11, exp_d: 2,  exp_e: 0}; tv.push_back(vr);
        vr = '{v: 15,  qq: 15, c: 2'b11, exp_d: 0,  exp_e: 0}; tv.push_back(vr);
        vr = '{v: -15, qq: 15, c: 2'b00, exp_d: 0,  exp_e: 0}; tv.push_back(vr);
        vr = '{v: 14,  qq: 15, c: 2'b01, exp_d: 14, exp_e: 0}; tv.push_back(vr);
        vr = '{v: 6,   qq: 7,  c: 2'b10, exp_d: 6,  exp_e: 1}; tv.push_back(vr);

        // Bring the DUT out of reset before any comparison.
        in_valid = 1'b0; var_1 = 5'sd0; q = 5'sd7; cmp = 2'b01;
        out_ready = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); last_d = 0; last_e = 0; m_cnt = 0;

        // Reset values.
        idle(1'b0);

        // Table vectors: 1-cycle latency, value and error flag.
        foreach (tv[i]) begin
            cycle(1'b1, tv[i].v, tv[i].qq, tv[i].c, 1'b1, 1'b0);
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_data",  int'(out_data),  tv[i].exp_d);
            chk("vec_err",   int'(out_err),   tv[i].exp_e);
            idle(1'b1);
        end
        chk("err_cnt_one", int'(err_cnt), 1);

        // Saturation of the illegal-code counter.
        for (int i = 0; i < 300; i++) cycle(1'b1, 6, 7, 2'b10, 1'b1, 1'b0);
        idle(1'b1);
        chk("err_cnt_sat", int'(err_cnt), 255);

        // Backpressure: two pushes fill the queue, third offer refused.
        cycle(1'b1, -1, 7, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 8, 7, 2'b11, 1'b0, 1'b0);
        chk("bp_in_ready_low", int'(in_ready), 0);
        cycle(1'b1, 3, 7, 2'b01, 1'b0, 1'b0);
        chk("bp_head_first", int'(out_data), 6);
        cycle(1'b0, 0, 7, 2'b01, 1'b1, 1'b0);
        chk("bp_in_ready_back", int'(in_ready), 1);
        chk("bp_head_second", int'(out_data), 1);
        idle(1'b1);
        chk("bp_drained", int'(out_valid), 0);

        // Streaming: ten back-to-back inputs with out_ready high.
        for (int i = 0; i < 10; i++) begin
            v = i - 5;
            c = {1'(v >= 7), 1'(v >= 0)};
            cycle(1'b1, v, 7, c, 1'b1, 1'b0);
        end
        idle(1'b1);

        // Reset mid-stream with a full queue and a pending handshake.
        cycle(1'b1, 1, 7, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 6, 7, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 2, 7, 2'b01, 1'b1, 1'b1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_err_cnt",   int'(err_cnt),   0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            v  = int'($urandom_range(0, 31)) - 16;
            qq = int'($urandom_range(1, 15));
            c  = {1'(v >= qq), 1'(v >= 0)};
            if ($urandom_range(0, 9) == 0) c = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), v, qq, c, 1'($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
